systolic_operand_feeder: RTL and testbench
==========================================

# systolic_operand_feeder

Edge controller for the bit-level N×N systolic multiplier array. It accepts operand pairs on a valid/ready input and drives the array's west and north edge bits with diagonal skew, so that bit A[r] and bit B[c] meet at processing element (r,c). After a fixed latency it samples the array's accumulated sum and returns the product on a valid/ready output. It is the transmit/collect end of the array edge interface; one operation is in flight at a time.

## Interface
- N, default 4: operand width and array dimension.
- RESULT_LAT, default 8: cycles from the first feed cycle to the cycle `sum_tail` holds the final product. Must be ≥ N.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- s_valid  in  1  operand pair valid
- s_ready  out  1  feeder can accept an operand pair
- s_a  in  N  multiplicand A
- s_b  in  N  multiplier B
- a_edge  out  N  bit r drives the row-r west edge of the array
- b_edge  out  N  bit c drives the column-c north edge of the array
- sum_tail  in  2N  accumulated sum from the array's final stage
- m_valid  out  1  product valid
- m_ready  in  1  consumer accepts product
- m_prod  out  2N  product A×B
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, FEED, WAIT, HOLD.
- IDLE: `s_ready`=1. When `s_valid`&`s_ready`, latch `s_a`/`s_b`, clear the phase counter, and go to FEED.
- FEED: lasts N cycles, phase k=0..N-1. In phase k, `a_edge`[k]=A[k] and `b_edge`[k]=B[k]; all other edge bits are 0. After phase N-1, go to WAIT.
- WAIT: all edge bits are 0. The counter continues. When the counter equals RESULT_LAT (measured from phase 0), capture `sum_tail` into `m_prod` and go to HOLD.
- HOLD: `m_valid`=1 and `m_prod` is stable. On `m_valid`&`m_ready`, go to IDLE.
- Input is ignored outside IDLE. `s_ready` is 0, and `s_valid` needs no hold.
- Arithmetic: the product is 2N bits wide and can never overflow. For N=4 the maximum is 15×15=225. The feeder performs no arithmetic on `sum_tail` and captures it verbatim.
- The counter is ceil(log2(RESULT_LAT+1)) bits wide and never wraps within an operation.

## Timing
- Reset values: `s_ready`=0 during reset and 1 on the first cycle after reset. `a_edge`=0, `b_edge`=0, `m_valid`=0, `m_prod`=0, `busy`=0. State is IDLE.
- Let T0 be the cycle where `s_valid`&`s_ready`. Then:
  - Phase k of FEED is cycle T0+1+k, with registered edge outputs.
  - `sum_tail` is sampled at cycle T0+1+RESULT_LAT.
  - `m_valid` rises at T0+2+RESULT_LAT.
- Minimum issue interval is RESULT_LAT+3 cycles with `m_ready` held high. The next `s_ready` comes the cycle after the output handshake.
- Backpressure: `m_valid` and `m_prod` hold indefinitely while `m_ready`=0.
- `m_ready` asserted before `m_valid` has no effect.
- Reset mid-operation (any state): on the next edge, return to IDLE with all reset values. The in-flight product is discarded with no `m_valid` pulse.

## Structure
- Shared package `systolic_pkg` holds:
  - The default N constant.
  - The PROD_W=2N localparam function.
  - The feeder state enum {IDLE, FEED, WAIT, HOLD}.
  - RESULT_LAT default, shared with the array wrapper so both agree on latency.
- Sub-module `edge_skew_shifter`:
  - Inputs: latched operand, phase index, feed-enable.
  - Outputs: registered one-hot-masked `a_edge`/`b_edge`.
  - Used twice (A/west and B/north) or once with a 2N-bit bus.
- The top level holds the FSM, phase/latency counter, result register and handshakes.

## Test plan
The bench uses a behavioural 4×4 array model with latency RESULT_LAT=8.

- A=15, B=15, `m_ready`=1 → in cycles T0+1..T0+4, `a_edge`=0001,0010,0100,1000 and likewise `b_edge`; `m_valid` at T0+10; `m_prod`=225.
- A=0, B=9 → `a_edge` all zero during FEED; `m_prod`=0 at T0+10; `s_ready` returns after the handshake.
- Back-to-back pairs (5,3) then (12,7), `m_ready` held 0 for 5 cycles on the first → 15 held stable through the stall; second pair accepted only after that handshake; second `m_prod`=84.
- `s_valid` pulsed during FEED/WAIT with A=1, B=1 → ignored; no extra `m_valid`; `s_ready` stays 0.
- `rst_n`=0 for one cycle at phase 2 of FEED → next cycle IDLE, edges 0, `m_valid`=0, `s_ready`=1; no stale product emitted.
- Exhaustive 256 pairs through the model → every `m_prod` equals A×B, and latency is exactly RESULT_LAT+2 from T0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants and types for the bit-level systolic multiplier and its edge feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package systolic_pkg;

   // Default operand width and array dimension.
   localparam int N_DEF = 4;

   // Cycles from the first feed cycle until the array's final stage holds the product.
   // Shared with the array wrapper so both sides agree on when to sample.
   localparam int RESULT_LAT_DEF = 8;

   // Product width for an n-bit by n-bit unsigned multiply; never overflows.
   function automatic int prod_w(input int n);
      return 2 * n;
   endfunction

   // Feeder control states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FEED = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } feeder_state_t;

endpackage

// File: rtl/edge_skew_shifter.sv
// Drives one array edge: presents exactly one operand bit per feed phase, all others zero.
// Latency: one cycle; inputs describe the next cycle and the masked bits are registered.
// Backpressure: none; the controller decides when a phase is presented.
module edge_skew_shifter #(
   parameter int W    = 4,
   parameter int PH_W = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [W-1:0]    opnd,
   input  logic [PH_W-1:0] phase,
   input  logic            feed,
   output logic [W-1:0]    edge_bits
);

   logic [W-1:0] mask;

   // One-hot select of the bit that belongs to this phase's row/column.
   always_comb begin
      mask = W'(1) << phase;
   end

   // Register the masked operand bit so the array edge sees clean, glitch-free levels.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         edge_bits <= '0;
      end else if (feed) begin
         edge_bits <= opnd & mask;
      end else begin
         edge_bits <= '0;
      end
   end

endmodule

// File: rtl/systolic_operand_feeder.sv
// Edge controller for the N x N bit-level systolic multiplier: skews operand bits onto the edges, collects the product.
// Latency: product valid RESULT_LAT+2 cycles after the input handshake; one operation in flight at a time.
// Backpressure: s_ready only in IDLE; m_valid/m_prod hold until m_ready, and the next operand waits for that handshake.
module systolic_operand_feeder
   import systolic_pkg::*;
#(
   parameter int N          = N_DEF,
   parameter int RESULT_LAT = RESULT_LAT_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [N-1:0]          s_a,
   input  logic [N-1:0]          s_b,
   output logic [N-1:0]          a_edge,
   output logic [N-1:0]          b_edge,
   input  logic [prod_w(N)-1:0]  sum_tail,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [prod_w(N)-1:0]  m_prod,
   output logic                  busy
);

   // The counter must reach RESULT_LAT without wrapping; RESULT_LAT >= N keeps FEED inside that range.
   localparam int CNT_W = $clog2(RESULT_LAT + 1);
   localparam int PH_W  = (N > 1) ? $clog2(N) : 1;

   feeder_state_t      state;
   feeder_state_t      state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [N-1:0]       a_q;
   logic [N-1:0]       b_q;
   logic [N-1:0]       a_nxt;
   logic [N-1:0]       b_nxt;
   logic               feed_nxt;
   logic               capture;
   logic [PH_W-1:0]    phase_nxt;

   // State and operand registers; reset drops any in-flight operation without a result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         a_q   <= '0;
         b_q   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         a_q   <= a_nxt;
         b_q   <= b_nxt;
      end
   end

   // Next-state, counter and handshake decode. The counter runs from phase 0 through WAIT so
   // sampling happens exactly RESULT_LAT cycles after the first feed cycle.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      a_nxt     = a_q;
      b_nxt     = b_q;
      feed_nxt  = 1'b0;
      capture   = 1'b0;
      s_ready   = 1'b0;
      m_valid   = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy    = 1'b0;
            s_ready = rst_n;
            if (s_valid) begin
               a_nxt     = s_a;
               b_nxt     = s_b;
               cnt_nxt   = '0;
               feed_nxt  = 1'b1;
               state_nxt = FEED;
            end
         end
         FEED: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_W'(N - 1)) begin
               state_nxt = WAIT;
            end else begin
               feed_nxt = 1'b1;
            end
         end
         WAIT: begin
            if (cnt == CNT_W'(RESULT_LAT)) begin
               capture   = 1'b1;
               state_nxt = HOLD;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         HOLD: begin
            // Gated by reset so a consumer never sees a handshake while the block is being cleared.
            m_valid = rst_n;
            if (m_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Phase of the cycle about to start; only meaningful while feed_nxt is high (cnt_nxt < N).
   always_comb begin
      phase_nxt = cnt_nxt[PH_W-1:0];
   end

   // Result register: the array's final stage is taken verbatim, no arithmetic here.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_prod <= '0;
      end else if (capture) begin
         m_prod <= sum_tail;
      end
   end

   // West edge: bit r of A presented in phase r.
   edge_skew_shifter #(
      .W    (N),
      .PH_W (PH_W)
   ) u_west (
      .clk       (clk),
      .rst_n     (rst_n),
      .opnd      (a_nxt),
      .phase     (phase_nxt),
      .feed      (feed_nxt),
      .edge_bits (a_edge)
   );

   // North edge: bit c of B presented in phase c.
   edge_skew_shifter #(
      .W    (N),
      .PH_W (PH_W)
   ) u_north (
      .clk       (clk),
      .rst_n     (rst_n),
      .opnd      (b_nxt),
      .phase     (phase_nxt),
      .feed      (feed_nxt),
      .edge_bits (b_edge)
   );

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Bench for systolic_operand_feeder with a behavioural 4x4 array model and an operation scoreboard.
// Latency: expects product valid RESULT_LAT+2 cycles after the input handshake.
// Backpressure: exercises m_ready stalls and ignored s_valid while busy.
module tb_systolic_operand_feeder;

   localparam int N  = 4;
   localparam int L  = 8;
   localparam int PW = 2 * N;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      int           t0;
   } op_t;

   logic          clk;
   logic          rst_n;
   logic          s_valid;
   logic          s_ready;
   logic [N-1:0]  s_a;
   logic [N-1:0]  s_b;
   logic [N-1:0]  a_edge;
   logic [N-1:0]  b_edge;
   logic [PW-1:0] sum_tail;
   logic          m_valid;
   logic          m_ready;
   logic [PW-1:0] m_prod;
   logic          busy;

   op_t           sb[$];
   int            cyc;
   int            hs_cyc;
   int            n_cmp;
   int            n_err;
   logic          mon_en;
   logic          mv_prev;
   logic [N-1:0]  a_rec;
   logic [N-1:0]  b_rec;

   systolic_operand_feeder #(
      .N          (N),
      .RESULT_LAT (L)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_a      (s_a),
      .s_b      (s_b),
      .a_edge   (a_edge),
      .b_edge   (b_edge),
      .sum_tail (sum_tail),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_prod   (m_prod),
      .busy     (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Accept tracking at the active edge: record each handshake, flush on reset.
   initial begin
      op_t op;
      cyc = 0;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            sb.delete();
         end else if (s_valid && s_ready) begin
            op.a  = s_a;
            op.b  = s_b;
            op.t0 = cyc;
            sb.push_back(op);
            a_rec = '0;
            b_rec = '0;
         end
         cyc++;
      end
   end

   // Array model and output checker, sampled just after the falling edge.
   initial begin
      int            d;
      int            k;
      logic [N-1:0]  ea;
      logic [N-1:0]  eb;
      logic [PW-1:0] mp;
      mv_prev = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (mon_en) begin
            if (sb.size() == 0) begin
               chk("idle_a_edge", 32'(a_edge), 32'd0);
               chk("idle_b_edge", 32'(b_edge), 32'd0);
               chk("idle_m_valid", 32'(m_valid), 32'd0);
               chk("idle_busy", 32'(busy), 32'd0);
               chk("idle_s_ready", 32'(s_ready), 32'(rst_n));
               sum_tail = 8'h5A;
            end else begin
               d  = cyc - sb[0].t0;
               k  = d - 1;
               ea = '0;
               eb = '0;
               if (k >= 0 && k < N) begin
                  ea[k] = sb[0].a[k];
                  eb[k] = sb[0].b[k];
               end
               chk("a_edge", 32'(a_edge), 32'(ea));
               chk("b_edge", 32'(b_edge), 32'(eb));
               chk("busy", 32'(busy), 32'd1);
               chk("s_ready_busy", 32'(s_ready), 32'd0);
               a_rec    = a_rec | a_edge;
               b_rec    = b_rec | b_edge;
               mp       = {4'b0, a_rec} * {4'b0, b_rec};
               sum_tail = (d == L + 1) ? mp : (mp ^ 8'hA5);
               chk("m_valid", 32'(m_valid), 32'(d >= L + 2));
               if (m_valid) begin
                  chk("m_prod", 32'(m_prod), 32'(int'(sb[0].a) * int'(sb[0].b)));
                  if (!mv_prev) chk("latency", 32'(d), 32'(L + 2));
                  if (m_ready) begin
                     hs_cyc = cyc;
                     void'(sb.pop_front());
                  end
               end
            end
            mv_prev = m_valid;
         end
      end
   end

   task automatic send(input logic [N-1:0] a, input logic [N-1:0] b);
      int w;
      w = 0;
      @(negedge clk);
      while (!s_ready && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (w >= 300) begin
         chk("s_ready_timeout", 32'd0, 32'd1);
      end else begin
         s_valid = 1'b1;
         s_a     = a;
         s_b     = b;
         @(negedge clk);
         s_valid = 1'b0;
         s_a     = N'($urandom);
         s_b     = N'($urandom);
      end
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while ((sb.size() != 0 || !s_ready) && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (w >= 300) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_mvalid();
      int w;
      w = 0;
      while (!m_valid && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (w >= 300) chk("m_valid_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      hs_cyc   = 0;
      mon_en   = 1'b0;
      rst_n    = 1'b0;
      s_valid  = 1'b0;
      s_a      = '0;
      s_b      = '0;
      m_ready  = 1'b1;
      sum_tail = '0;
      a_rec    = '0;
      b_rec    = '0;

      // Reset values.
      repeat (3) @(negedge clk);
      #1;
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_a_edge", 32'(a_edge), 32'd0);
      chk("rst_b_edge", 32'(b_edge), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_prod", 32'(m_prod), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      #1;
      chk("post_rst_s_ready", 32'(s_ready), 32'd1);

      // Full-scale operands: every edge bit walks through.
      send(4'd15, 4'd15);
      wait_idle();

      // Zero multiplicand; s_ready returns after the handshake.
      send(4'd0, 4'd9);
      wait_idle();
      chk("s_ready_after_hs", 32'(s_ready), 32'd1);

      // Output stall on the first of two pairs.
      m_ready = 1'b0;
      send(4'd5, 4'd3);
      wait_mvalid();
      repeat (5) begin
         @(negedge clk);
         #1;
         chk("stall_m_prod", 32'(m_prod), 32'd15);
         chk("stall_s_ready", 32'(s_ready), 32'd0);
      end
      @(negedge clk);
      m_ready = 1'b1;
      send(4'd12, 4'd7);
      if (sb.size() != 0) chk("b2b_t0", 32'(sb[0].t0), 32'(hs_cyc + 1));
      else chk("b2b_inflight", 32'd0, 32'd1);
      wait_idle();

      // s_valid pulses while busy must be ignored.
      send(4'd6, 4'd9);
      s_valid = 1'b1;
      s_a     = 4'd1;
      s_b     = 4'd1;
      #1;
      chk("ign_feed_s_ready", 32'(s_ready), 32'd0);
      @(negedge clk);
      s_valid = 1'b0;
      repeat (4) @(negedge clk);
      s_valid = 1'b1;
      #1;
      chk("ign_wait_s_ready", 32'(s_ready), 32'd0);
      @(negedge clk);
      s_valid = 1'b0;
      wait_idle();
      repeat (15) @(negedge clk);

      // Reset during phase 2 of FEED.
      send(4'd10, 4'd11);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_rst_s_ready", 32'(s_ready), 32'd1);
      chk("mid_rst_a_edge", 32'(a_edge), 32'd0);
      chk("mid_rst_b_edge", 32'(b_edge), 32'd0);
      chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      repeat (15) @(negedge clk);

      // Every operand pair.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            send(N'(a), N'(b));
         end
      end
      wait_idle();
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #400000;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog");
   end

endmodule
